uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit stage sitting directly downstream of the TX fifo_buffer. It pops one byte at a time from the FIFO and serializes it onto txd as a standard asynchronous frame: start bit, DATA_BITS data bits LSB first, optional parity, then 1 or 2 stop bits. The FIFO is passive, so this block owns the read handshake (fifo_rd_en) and drains the FIFO whenever it is non-empty and enabled.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be >= 2)
DATA_BITS, 8, data bits per frame (5..8); must equal the FIFO WIDTH
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, active-low, asynchronous
enable  input  1  permits starting a new frame; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_BITS  FIFO data_out (registered, valid the cycle after a read)
fifo_rd_en  output  1  FIFO read strobe, exactly one cycle per byte
txd  output  1  serial line, idle high
busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, txd = 1, fifo_rd_en = 0, busy = 0, tx_done = 0, baud counter = 0, bit index = 0, shift register = 0. Takes effect immediately and overrides any frame in progress. A byte already popped from the FIFO is lost.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The FSM has 7 states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: txd = 1. On an edge where enable = 1 and fifo_empty = 0, go to FETCH and set fifo_rd_en = 1.
- FETCH: lasts 1 cycle, with fifo_rd_en high for this cycle only. The FIFO samples the strobe at the end of this cycle. Go to LOAD and clear fifo_rd_en.
- LOAD: lasts 1 cycle. At its closing edge, capture fifo_data into the shift register, compute parity (even = XOR of the data bits; odd = its inverse), go to START and drive txd = 0.
- START: txd = 0 for CLKS_PER_BIT cycles.
- DATA: sends DATA_BITS bits, LSB first, each held for CLKS_PER_BIT cycles.
- PARITY: present only when PARITY_MODE != 0. txd = parity bit for CLKS_PER_BIT cycles. When PARITY_MODE = 0 the state is skipped.
- STOP: txd = 1 for STOP_BITS × CLKS_PER_BIT cycles. On the final cycle's edge, go to IDLE and pulse tx_done for 1 cycle.
- Latency: txd falls 3 clocks after the first edge that sees enable and !fifo_empty. That edge gives IDLE→FETCH, then FETCH→LOAD, then LOAD→START.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from txd falling to the tx_done edge.
- Back-to-back frames: when the FIFO is still non-empty in IDLE, the next fetch starts on the IDLE cycle after tx_done. This gives exactly 3 extra idle-high cycles between frames (IDLE, FETCH, LOAD).
- enable is ignored outside IDLE. Deasserting it mid-frame never truncates a frame.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT−1, wraps at each bit boundary, and resets to 0 on every state change.
- fifo_data is read only at the LOAD edge. FIFO contents or emptiness changing mid-frame have no effect on the current frame.
- fifo_rd_en is never asserted while fifo_empty = 1 in IDLE. It never pulses twice per frame.

Test Plan:
1. Use CLK_FREQ=400, BAUD_RATE=100 (CLKS_PER_BIT=4), 8N1. Load 0xA5 into the FIFO and raise enable. Required: fifo_rd_en pulses once; txd falls 3 clocks later; txd then shows 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; tx_done pulses at cycle 40 after the fall; busy drops the same cycle.
2. Even parity, 0x07, 8E1. Required: parity bit = 1 and frame = 44 cycles. Odd parity, same byte: parity bit = 0.
3. Load 3 bytes 0x01, 0x80, 0xFF with enable held. Required: three frames in order, each separated by exactly 3 idle-high cycles, and exactly 3 fifo_rd_en pulses.
4. FIFO empty with enable = 1 for 100 cycles. Required: txd = 1, fifo_rd_en = 0, busy = 0 throughout. Then hold enable = 0 while the FIFO is non-empty: no fetch occurs. Dropping enable mid-frame: the frame still completes.
5. Assert rst low in the middle of the DATA state, asynchronously between clock edges. Required: txd = 1 and busy = 0 immediately. After release, the next FIFO byte transmits normally.
6. STOP_BITS=2, DATA_BITS=7, 0x55, CLKS_PER_BIT=4. Required: stop high for 8 cycles, frame = 40 cycles, tx_done pulse at that edge.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit stage placed directly after the TX fifo_buffer. It pops one
// byte at a time from the FIFO (owning the fifo_rd_en handshake) and shifts
// it out on txd as an asynchronous frame: start bit, DATA_BITS data bits LSB
// first, optional parity bit, then STOP_BITS stop bits. Every output is a
// flop, so nothing combinational runs from the inputs to the outputs.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous reset, active low
//   enable     - permits starting a new frame, only looked at in IDLE
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO data_out, valid the cycle after a read strobe
//   fifo_rd_en - FIFO read strobe, one cycle per byte
//   txd        - serial line, idles high
//   busy       - high whenever the serializer is not in IDLE
//   tx_done    - one-cycle pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
  logic                 parity_bit, parity_bit_n;
  logic                 txd_n, rd_en_n, busy_n, done_n;
  logic                 bit_end;

  // Last clock of the current bit period.
  assign bit_end = (baud_cnt == CNT_LAST);

  // State and datapath registers. Reset drops any frame in progress and
  // returns the line to its idle-high level straight away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      shift_reg  <= shift_reg_n;
      parity_bit <= parity_bit_n;
      txd        <= txd_n;
      fifo_rd_en <= rd_en_n;
      busy       <= busy_n;
      tx_done    <= done_n;
    end
  end

  // Next-state and next-output logic. The baud counter defaults to 0 so it
  // clears on every state change and at every bit boundary; each bit state
  // only advances it while the current bit is still running.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = '0;
    bit_idx_n    = bit_idx;
    shift_reg_n  = shift_reg;
    parity_bit_n = parity_bit;
    txd_n        = txd;
    rd_en_n      = 1'b0;
    done_n       = 1'b0;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (enable && !fifo_empty) begin
          state_n = FETCH;
          rd_en_n = 1'b1;
        end
      end

      // The FIFO samples the strobe at the end of this cycle.
      FETCH: state_n = LOAD;

      // fifo_data is valid now because the FIFO output is registered.
      LOAD: begin
        state_n      = START;
        shift_reg_n  = fifo_data;
        parity_bit_n = (PARITY_MODE == 2) ? ~(^fifo_data) : (^fifo_data);
        bit_idx_n    = '0;
        txd_n        = 1'b0;
      end

      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          txd_n     = shift_reg[0];
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      // Shift right so the next data bit always sits in shift_reg[1].
      DATA: begin
        if (bit_end) begin
          if (bit_idx == DATA_LAST) begin
            bit_idx_n = '0;
            if (PARITY_MODE != 0) begin
              state_n = PARITY;
              txd_n   = parity_bit;
            end else begin
              state_n = STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_idx_n   = bit_idx + 3'd1;
            shift_reg_n = shift_reg >> 1;
            txd_n       = shift_reg[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_n   = STOP;
          bit_idx_n = '0;
          txd_n     = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      // bit_idx is reused here to count stop bits.
      STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            state_n   = IDLE;
            bit_idx_n = '0;
            done_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Drives several serializer configurations from simple FIFO models and
// compares every clock of every frame against a reference built from the
// frame format: start 0, data LSB first, optional parity, then stop ones.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int NI   = 5;
  localparam int BAUD = 100;
  localparam int CF [NI] = '{400, 400, 400, 400, 300};
  localparam int DB [NI] = '{8, 8, 8, 7, 6};
  localparam int PM [NI] = '{0, 1, 2, 0, 2};
  localparam int SB [NI] = '{1, 1, 1, 2, 2};

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] enable = '0;
  logic [NI-1:0] fifo_empty;
  logic [NI-1:0] rd_en;
  logic [NI-1:0] txd;
  logic [NI-1:0] busy;
  logic [NI-1:0] tx_done;

  logic [7:0] mem [NI][64];
  int         wr_cnt [NI] = '{default: 0};
  int         pop_cnt [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // One FIFO model and one DUT per configuration.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DB[g]-1:0] dout = '0;
    int               rd_ptr = 0;

    always @(posedge clk) begin
      if (rd_en[g]) begin
        dout   <= mem[g][rd_ptr % 64][DB[g]-1:0];
        rd_ptr <= rd_ptr + 1;
      end
    end

    assign fifo_empty[g] = (rd_ptr >= wr_cnt[g]);
    assign pop_cnt[g]    = rd_ptr;

    uart_tx_serializer #(
      .CLK_FREQ   (CF[g]),
      .BAUD_RATE  (BAUD),
      .DATA_BITS  (DB[g]),
      .PARITY_MODE(PM[g]),
      .STOP_BITS  (SB[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst_n),
      .enable    (enable[g]),
      .fifo_empty(fifo_empty[g]),
      .fifo_data (dout),
      .fifo_rd_en(rd_en[g]),
      .txd       (txd[g]),
      .busy      (busy[g]),
      .tx_done   (tx_done[g])
    );
  end

  // Compare, count, and report a single observation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input int k);
    return 8'((1 << DB[k]) - 1);
  endfunction

  // Push one byte into FIFO k.
  task automatic applyStimulus(input int k, input logic [7:0] d);
    mem[k][wr_cnt[k] % 64] = d & mask_of(k);
    wr_cnt[k]++;
  endtask

  // Line level expected during bit i of a frame carrying d.
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB[k]) return d[i-1];
    if (PM[k] != 0 && i == DB[k] + 1) return (PM[k] == 1) ? (^d) : ~(^d);
    return 1'b1;
  endfunction

  function automatic int frame_bits(input int k);
    return 1 + DB[k] + ((PM[k] != 0) ? 1 : 0) + SB[k];
  endfunction

  function automatic logic [31:0] status(input int k);
    return 32'({busy[k], tx_done[k], rd_en[k]});
  endfunction

  // Called right after the negedge at which the DUT becomes eligible to
  // fetch: FETCH, LOAD, then the full frame, then the tx_done cycle.
  task automatic checkFrame(input int k, input logic [7:0] d, input int drop_at);
    int cpb;
    int nb;
    cpb = CF[k] / BAUD;
    nb  = frame_bits(k);
    @(negedge clk);
    checkOutput($sformatf("u%0d fetch status", k), status(k), 32'b101);
    checkOutput($sformatf("u%0d fetch txd", k), 32'(txd[k]), 32'd1);
    @(negedge clk);
    checkOutput($sformatf("u%0d load status", k), status(k), 32'b100);
    checkOutput($sformatf("u%0d load txd", k), 32'(txd[k]), 32'd1);
    for (int c = 0; c < nb * cpb; c++) begin
      @(negedge clk);
      checkOutput($sformatf("u%0d byte %0h txd cycle %0d", k, d, c), 32'(txd[k]),
                  32'(exp_bit(k, d, c / cpb)));
      checkOutput($sformatf("u%0d status cycle %0d", k, c), status(k), 32'b100);
      if (c == drop_at) enable[k] = 1'b0;
    end
    @(negedge clk);
    checkOutput($sformatf("u%0d done status", k), status(k), 32'b010);
    checkOutput($sformatf("u%0d done txd", k), 32'(txd[k]), 32'd1);
  endtask

  task automatic checkIdle(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checkOutput($sformatf("u%0d idle txd", k), 32'(txd[k]), 32'd1);
      checkOutput($sformatf("u%0d idle status", k), status(k), 32'b000);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] burst [4];
    int         k;
    int         n;
    int         drop;

    $display("[TB] starting uart_tx_serializer bench");

    // Reset state of every configuration.
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("u%0d reset txd", i), 32'(txd[i]), 32'd1);
      checkOutput($sformatf("u%0d reset status", i), status(i), 32'b000);
    end
    rst_n = 1'b1;
    checkIdle(0, 2);

    // 8N1 single byte, then stays idle once the FIFO is drained.
    applyStimulus(0, 8'hA5);
    enable[0] = 1'b1;
    checkFrame(0, 8'hA5, -1);
    checkOutput("u0 pops after A5", 32'(pop_cnt[0]), 32'(wr_cnt[0]));
    checkIdle(0, 5);
    enable[0] = 1'b0;

    // Even and odd parity with the same byte.
    applyStimulus(1, 8'h07);
    enable[1] = 1'b1;
    checkFrame(1, 8'h07, -1);
    enable[1] = 1'b0;
    applyStimulus(2, 8'h07);
    enable[2] = 1'b1;
    checkFrame(2, 8'h07, -1);
    enable[2] = 1'b0;

    // Three back-to-back frames.
    applyStimulus(0, 8'h01);
    applyStimulus(0, 8'h80);
    applyStimulus(0, 8'hFF);
    enable[0] = 1'b1;
    checkFrame(0, 8'h01, -1);
    checkFrame(0, 8'h80, -1);
    checkFrame(0, 8'hFF, -1);
    checkOutput("u0 pops after burst", 32'(pop_cnt[0]), 32'(wr_cnt[0]));

    // Empty FIFO with enable high, then data present with enable low.
    checkIdle(0, 100);
    enable[0] = 1'b0;
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'hC3);
    checkIdle(0, 20);
    enable[0] = 1'b1;
    checkFrame(0, 8'h3C, 12);
    checkIdle(0, 10);
    enable[0] = 1'b1;
    checkFrame(0, 8'hC3, -1);
    checkOutput("u0 pops after enable test", 32'(pop_cnt[0]), 32'(wr_cnt[0]));
    enable[0] = 1'b0;

    // Asynchronous reset in the middle of the data bits.
    applyStimulus(0, 8'h96);
    applyStimulus(0, 8'h69);
    enable[0] = 1'b1;
    repeat (16) @(negedge clk);
    checkOutput("u0 busy before reset", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("u0 txd at reset", 32'(txd[0]), 32'd1);
    checkOutput("u0 status at reset", status(0), 32'b000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("u0 txd held in reset", 32'(txd[0]), 32'd1);
    rst_n = 1'b1;
    checkFrame(0, 8'h69, -1);
    checkOutput("u0 pops after reset", 32'(pop_cnt[0]), 32'(wr_cnt[0]));
    enable[0] = 1'b0;

    // 7 data bits, two stop bits.
    applyStimulus(3, 8'h55);
    enable[3] = 1'b1;
    checkFrame(3, 8'h55, -1);
    enable[3] = 1'b0;

    // Random bursts across all configurations.
    for (int it = 0; it < 14; it++) begin
      k = int'($urandom_range(0, NI - 1));
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        burst[j] = 8'($urandom) & mask_of(k);
        applyStimulus(k, burst[j]);
      end
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
      enable[k] = 1'b1;
      for (int j = 0; j < n; j++)
        checkFrame(k, burst[j], (j == n - 1) ? drop : -1);
      enable[k] = 1'b0;
      checkIdle(k, 2);
      checkOutput($sformatf("u%0d pops after random burst %0d", k, it), 32'(pop_cnt[k]),
                  32'(wr_cnt[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
